regfile_wport_arbiter: RTL and testbench
========================================

Name: regfile_wport_arbiter

Overview:
- Shares the single register-file write port (write_reg / write_data / reg_write) among NUM_REQ writeback requesters, e.g. ALU, load unit and CSR unit.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives the register-file write port from registered outputs.
- Optionally sequences a post-reset clear of x1..x31, because the register file itself has no reset.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register index width (32 registers).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester grant; at most one bit high per cycle.
- req_rd  in  NUM_REQ*ADDR_WIDTH  packed destination indices; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- rf_write_reg  out  ADDR_WIDTH  to register file write_reg.
- rf_write_data  out  DATA_WIDTH  to register file write_data.
- rf_reg_write  out  1  to register file reg_write.
- grant_id  out  max(1,$clog2(NUM_REQ))  index of the requester granted this cycle; valid only when |req_ready.
- init_busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (async assert on reset_n=0):
  - rf_write_reg=0, rf_write_data=0, rf_reg_write=0.
  - req_ready=0, init_busy=0, rr_ptr=0.
  - Any accepted-but-not-yet-driven write is discarded.
  - The FSM enters INIT if RF_CLEAR_ON_RESET_EN is defined, otherwise ARB.
- ARB state, combinational grant:
  - Search req_valid starting at rr_ptr, ascending with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - The first valid requester gets req_ready=1 in the same cycle; grant_id = that index.
  - No valid requester: req_ready=0 and grant_id=0.
- Handshake: transfer occurs when req_valid[i] & req_ready[i].
  - On transfer, rr_ptr <= (i+1) mod NUM_REQ.
  - rr_ptr is unchanged when no transfer occurs.
- Requester rule: once req_valid[i] rises, req_valid, req_rd and req_data must stay stable until the transfer. The bench checks this with an assertion; the RTL does not tolerate violations.
- Write latency is exactly 1 cycle. On the edge ending the transfer cycle:
  - rf_write_reg <= req_rd[i], rf_write_data <= req_data[i].
  - rf_reg_write <= 1 if req_rd[i] != 0, else 0. A write to x0 is still accepted (ready=1) but suppressed.
- No transfer in a cycle: rf_reg_write <= 0 on the next edge. rf_write_reg and rf_write_data hold their last values.
- Throughput: one write per cycle. Back-to-back grants to different requesters are allowed every cycle.
- Two requesters valid in the same cycle: exactly one is served. The other stays valid and wins the following cycle if no higher-rotated requester intervenes.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Same-rd conflicts: ordering between requesters is grant order only. Hazard resolution is out of scope.

Optional Feature:
- Macro: RF_CLEAR_ON_RESET_EN.
- Defined:
  - After reset_n deasserts, the FSM is in INIT with counter=1.
  - Each cycle in INIT: rf_write_reg=counter, rf_write_data=0, rf_reg_write=1 (registered, so these appear from the first edge after reset release), init_busy=1, req_ready=0, and counter increments.
  - After writing x31 (31 write cycles), INIT -> ARB, init_busy <= 0, rf_reg_write <= 0.
  - The first grant is possible in the first cycle with init_busy=0.
  - Reset during INIT restarts the sequence from x1.
- Undefined: no INIT state or counter; init_busy is tied 0; ARB is entered directly from reset.

Test Plan:
- Single request: req 1 valid, rd=5, data=0xDEADBEEF -> same cycle req_ready=3'b010 and grant_id=1; next cycle rf_reg_write=1, rf_write_reg=5, rf_write_data=0xDEADBEEF; following cycle rf_reg_write=0.
- Contention: reqs 0,1,2 all valid from the first ARB cycle with rr_ptr=0, each dropping valid after its transfer -> grants 0,1,2 on three consecutive cycles; rf_reg_write high for 3 consecutive cycles with matching rd/data.
- Fairness: req 0 continuously re-requests, req 2 valid and held -> req 2 granted within 3 cycles; req 0 never granted twice in a row while req 2 waits.
- x0 write: req 0 rd=0, data=0x1234 -> ready=1 and handshake completes; next cycle rf_reg_write=0.
- Reset mid-operation: assert reset_n=0 in the cycle after a handshake -> rf_reg_write=0 immediately (async) and the write is never issued; after release, rr_ptr=0.
- With RF_CLEAR_ON_RESET_EN: after reset release -> 31 cycles of rf_reg_write=1 with rf_write_reg 1..31 and data 0, req_ready=0 throughout; init_busy falls; a pending req then gets granted.

Source files
------------

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the single register-file write port among
// NUM_REQ writeback requesters using round-robin arbitration with a
// valid/ready handshake. The write port is driven from registers, one cycle
// after the handshake.
//
// Optional feature (macro RF_CLEAR_ON_RESET_EN): after reset release, writes
// zero to x1..x(2^ADDR_WIDTH-1) before any requester is granted, because the
// register file itself has no reset.
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   req_valid      per-requester write request
//   req_ready      per-requester grant (combinational, one-hot or zero)
//   req_rd         packed destination indices, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data       packed write data, same packing
//   rf_write_reg   register-file write index (registered)
//   rf_write_data  register-file write data (registered)
//   rf_reg_write   register-file write enable (registered)
//   grant_id       index of the granted requester (combinational, valid when |req_ready)
//   init_busy      high while the clear sequence runs (registered)
module regfile_wport_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [ADDR_WIDTH-1:0]            rf_write_reg,
  output logic [DATA_WIDTH-1:0]            rf_write_data,
  output logic                             rf_reg_write,
  output logic [ID_W-1:0]                  grant_id,
  output logic                             init_busy
);

  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam int unsigned SUM_W = ID_W + 1;

  logic [ID_W-1:0]       rr_ptr;
  logic                  arb_en;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [SUM_W-1:0]      sum;
  logic [ID_W-1:0]       idx;
  logic [ADDR_WIDTH-1:0] rd_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // Unpack the per-requester fields.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rd_arr[g]   = req_rd[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    xfer      = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    sum       = '0;
    idx       = '0;
    if (arb_en) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        sum = SUM_W'(rr_ptr) + SUM_W'(k);
        idx = (sum >= SUM_W'(NUM_REQ)) ? ID_W'(sum - SUM_W'(NUM_REQ)) : ID_W'(sum);
        if (!xfer && req_valid[idx]) begin
          xfer           = 1'b1;
          req_ready[idx] = 1'b1;
          grant_id       = idx;
          sel_rd         = rd_arr[idx];
          sel_data       = data_arr[idx];
        end
      end
    end
  end

  // Pointer moves just past the winner after every transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

`ifdef RF_CLEAR_ON_RESET_EN
  typedef enum logic {ST_INIT, ST_ARB} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_REG = '1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_nxt;
  end

  // Next state; grants wait until init_busy has actually dropped.
  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    if (state == ST_INIT) begin
      if (clr_cnt == LAST_REG) state_nxt = ST_ARB;
    end else begin
      arb_en = !init_busy;
    end
  end

  // Write port: clear sweep in INIT, granted request otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      rf_reg_write  <= 1'b0;
      init_busy     <= 1'b0;
      clr_cnt       <= ADDR_WIDTH'(1);
    end else if (state == ST_INIT) begin
      rf_write_reg  <= clr_cnt;
      rf_write_data <= '0;
      rf_reg_write  <= 1'b1;
      init_busy     <= 1'b1;
      clr_cnt       <= clr_cnt + ADDR_WIDTH'(1);
    end else begin
      init_busy    <= 1'b0;
      rf_reg_write <= xfer && (sel_rd != '0);
      if (xfer) begin
        rf_write_reg  <= sel_rd;
        rf_write_data <= sel_data;
      end
    end
  end
`else
  assign arb_en    = 1'b1;
  assign init_busy = 1'b0;

  // Write port: register the granted request; x0 writes are suppressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      rf_reg_write  <= 1'b0;
    end else begin
      rf_reg_write <= xfer && (sel_rd != '0);
      if (xfer) begin
        rf_write_reg  <= sel_rd;
        rf_write_data <= sel_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter with hand-computed expectations.
module tb_regfile_wport_arbiter;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 5;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*AW-1:0] req_rd;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [AW-1:0]         rf_write_reg;
  logic [DW-1:0]         rf_write_data;
  logic                  rf_reg_write;
  logic [1:0]            grant_id;
  logic                  init_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rd        (req_rd),
    .req_data      (req_data),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rf_reg_write  (rf_reg_write),
    .grant_id      (grant_id),
    .init_busy     (init_busy)
  );

  // Requester rule: a pending request holds valid, rd and data until transfer.
  logic [NUM_REQ-1:0]    hold_q;
  logic [NUM_REQ*AW-1:0] rd_q;
  logic [NUM_REQ*DW-1:0] data_q;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hold_q[i]) begin
          assert (req_valid[i] && req_rd[i*AW +: AW] == rd_q[i*AW +: AW] &&
                  req_data[i*DW +: DW] == data_q[i*DW +: DW])
            else $error("requester %0d changed its pending request", i);
        end
      end
      hold_q <= req_valid & ~req_ready;
      rd_q   <= req_rd;
      data_q <= req_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    req_rd[i*AW +: AW]   = rd;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [AW-1:0] rd,
                          input logic [DW-1:0] d);
    chk({tag, "_we"},   64'(rf_reg_write),  64'(we));
    chk({tag, "_reg"},  64'(rf_write_reg),  64'(rd));
    chk({tag, "_data"}, 64'(rf_write_data), 64'(d));
  endtask

  // Release reset; with the clear feature, also check the sweep and serve a
  // request that was pending throughout it (leaves rr_ptr at 0 again).
  task automatic reset_release();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
`ifdef RF_CLEAR_ON_RESET_EN
    set_req(2, 5'd4, 32'h00C0FFEE);
    req_valid = 3'b100;
    #1;
    chk("init_ready0", 64'(req_ready), 64'(3'b000));
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk($sformatf("init_we_%0d", k),   64'(rf_reg_write),  64'(1));
      chk($sformatf("init_reg_%0d", k),  64'(rf_write_reg),  64'(k));
      chk($sformatf("init_data_%0d", k), 64'(rf_write_data), 64'(0));
      chk($sformatf("init_busy_%0d", k), 64'(init_busy),     64'(1));
      chk($sformatf("init_rdy_%0d", k),  64'(req_ready),     64'(3'b000));
    end
    tick();
    chk("init_done_busy", 64'(init_busy),    64'(0));
    chk("init_done_we",   64'(rf_reg_write), 64'(0));
    chk("init_pend_rdy",  64'(req_ready),    64'(3'b100));
    chk("init_pend_gid",  64'(grant_id),     64'(2));
    tick();
    req_valid = '0;
    check_wr("init_pend_wr", 1'b1, 5'd4, 32'h00C0FFEE);
    tick();
    chk("init_pend_idle", 64'(rf_reg_write), 64'(0));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    #2;
    check_wr("rst", 1'b0, 5'd0, 32'h0);
    chk("rst_ready", 64'(req_ready), 64'(3'b000));
    chk("rst_gid",   64'(grant_id),  64'(0));
    chk("rst_busy",  64'(init_busy), 64'(0));
    reset_release();

    // Single request from requester 1.
    set_req(1, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1;
    chk("t1_ready", 64'(req_ready), 64'(3'b010));
    chk("t1_gid",   64'(grant_id),  64'(1));
    tick();
    req_valid = '0;
    check_wr("t1_wr", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk("t1_idle", 64'(rf_reg_write), 64'(0));
    chk("t1_hold", 64'(rf_write_reg), 64'(5));

    // Contention from rr_ptr=0: grants 0,1,2 back to back.
    reset_n = 1'b0;
    #1;
    reset_release();
    set_req(0, 5'd1, 32'hA0);
    set_req(1, 5'd2, 32'hA1);
    set_req(2, 5'd3, 32'hA2);
    req_valid = 3'b111;
    #1;
    chk("c_rdy0", 64'(req_ready), 64'(3'b001));
    chk("c_gid0", 64'(grant_id),  64'(0));
    tick();
    req_valid = 3'b110;
    #1;
    check_wr("c_wr0", 1'b1, 5'd1, 32'hA0);
    chk("c_rdy1", 64'(req_ready), 64'(3'b010));
    chk("c_gid1", 64'(grant_id),  64'(1));
    tick();
    req_valid = 3'b100;
    #1;
    check_wr("c_wr1", 1'b1, 5'd2, 32'hA1);
    chk("c_rdy2", 64'(req_ready), 64'(3'b100));
    chk("c_gid2", 64'(grant_id),  64'(2));
    tick();
    req_valid = '0;
    #1;
    check_wr("c_wr2", 1'b1, 5'd3, 32'hA2);
    chk("c_rdy_none", 64'(req_ready), 64'(3'b000));
    tick();
    chk("c_idle", 64'(rf_reg_write), 64'(0));

    // Fairness: req 0 keeps requesting, req 2 must win the next slot.
    set_req(0, 5'd7, 32'h70);
    set_req(2, 5'd9, 32'h90);
    req_valid = 3'b101;
    #1;
    chk("f_gid0", 64'(grant_id), 64'(0));
    tick();
    check_wr("f_wr0", 1'b1, 5'd7, 32'h70);
    chk("f_gid1", 64'(grant_id), 64'(2));
    tick();
    req_valid = 3'b001;
    #1;
    check_wr("f_wr1", 1'b1, 5'd9, 32'h90);
    chk("f_gid2", 64'(grant_id), 64'(0));
    tick();
    req_valid = '0;
    check_wr("f_wr2", 1'b1, 5'd7, 32'h70);

    // Write to x0: accepted but suppressed.
    set_req(0, 5'd0, 32'h1234);
    req_valid = 3'b001;
    #1;
    chk("x0_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    check_wr("x0_wr", 1'b0, 5'd0, 32'h1234);
    tick();
    chk("x0_idle", 64'(rf_reg_write), 64'(0));

    // Reset while a write is on the port, then rr_ptr must be back at 0.
    set_req(1, 5'd12, 32'h55);
    req_valid = 3'b010;
    #1;
    chk("m_ready", 64'(req_ready), 64'(3'b010));
    tick();
    req_valid = '0;
    chk("m_pending_we", 64'(rf_reg_write), 64'(1));
    reset_n = 1'b0;
    #1;
    check_wr("m_rst", 1'b0, 5'd0, 32'h0);
    tick();
    chk("m_rst_we", 64'(rf_reg_write), 64'(0));
    reset_release();
    set_req(0, 5'd3, 32'h30);
    set_req(2, 5'd6, 32'h60);
    req_valid = 3'b101;
    #1;
    chk("m_ptr_gid", 64'(grant_id),  64'(0));
    chk("m_ptr_rdy", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = 3'b100;
    #1;
    check_wr("m_wr0", 1'b1, 5'd3, 32'h30);
    chk("m_gid2", 64'(grant_id), 64'(2));
    tick();
    req_valid = '0;
    check_wr("m_wr1", 1'b1, 5'd6, 32'h60);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
